// File: rtl/de1_pkg.sv
// Shared definitions for the DE1 front-panel controller.
// Holds the display mode enum, active-low seven-segment glyph constants
// (bit order gfedcba), the nibble-to-glyph decoder and the switch mode decoder.
package de1_pkg;

  typedef enum logic [2:0] {
    MODE_ID,
    MODE_ECHO,
    MODE_MANUAL,
    MODE_AUTO,
    MODE_INVALID
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

  // One-hot style codes on sw[9:5]; anything else is treated as invalid.
  function automatic mode_e decode_mode(input logic [4:0] code);
    mode_e m;
    case (code)
      5'b00000: m = MODE_ID;
      5'b10000: m = MODE_ECHO;
      5'b01000: m = MODE_MANUAL;
      5'b00100: m = MODE_AUTO;
      default:  m = MODE_INVALID;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/de1_counter_display_if.sv
// Front-panel bundle of the DE1 board: slide switches and pushbuttons in,
// red/green LEDs and seven-segment digits out.
//   sw   [9:0]            slide switches (asynchronous)
//   key  [3:0]            pushbuttons, active-low, bouncing
//   ledr [9:0]            red LEDs
//   ledg [7:0]            green LEDs
//   hex  [7*NUM_DIGITS-1:0] active-low segments, digit i at [7i+6:7i]
// master = board / stimulus side, slave = the controller.
interface de1_counter_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic [9:0]              sw;
  logic [3:0]              key;
  logic [9:0]              ledr;
  logic [7:0]              ledg;
  logic [7*NUM_DIGITS-1:0] hex;

  modport master (output sw, key, input ledr, ledg, hex);
  modport slave  (input sw, key, output ledr, ledg, hex);
endinterface

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, per-key stability counter and
// one-cycle press pulses.
//   clk_i, rst_i   clock and asynchronous active-high reset
//   key_n_i        raw active-low keys
//   pressed_o      accepted (debounced) state, 1 = pressed
//   press_o        one-cycle pulse on each accepted release->press transition
module key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] key_n_i,
  output logic [WIDTH-1:0] pressed_o,
  output logic [WIDTH-1:0] press_o
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] acc_q, acc_d, acc_dly_q, press_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  assign raw = ~sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // Synchroniser resets to "released" so no phantom edge appears.
      meta_q    <= '1;
      sync_q    <= '1;
      acc_q     <= '0;
      acc_dly_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q    <= key_n_i;
      sync_q    <= meta_q;
      acc_q     <= acc_d;
      acc_dly_q <= acc_q;
      press_q   <= acc_q & ~acc_dly_q;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Counter tracks consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts it, so short bounces never get through.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != acc_q[i]) begin
        if (cnt_q[i] == LAST) acc_d[i] = raw[i];
        else                  cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign pressed_o = acc_q;
  assign press_o   = press_q;

endmodule

// File: rtl/de1_counter_display.sv
// DE1 front-panel controller: decodes a display mode from sw[9:5] and drives
// the seven-segment digits and LEDs from a class ID, a switch echo, or a
// shared counter (key-stepped or prescaler-ticked).
//   clock  board clock, single domain
//   reset  asynchronous active-high reset
//   pnl    front-panel bundle (slave side): sw, key in; ledr, ledg, hex out
module de1_counter_display
  import de1_pkg::*;
#(
  parameter int          CNT_WIDTH       = 16,
  parameter int          NUM_DIGITS      = 4,
  parameter int          DEBOUNCE_CYCLES = 240000,
  parameter int          TICK_CYCLES     = 24000000,
  parameter logic [15:0] CLASS_ID        = 16'h0076
) (
  input logic            clock,
  input logic            reset,
  de1_counter_display_if.slave pnl
);
  localparam int            PW        = $clog2(TICK_CYCLES + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam int            ID_DIGITS = (NUM_DIGITS < 4) ? NUM_DIGITS : 4;
  localparam int            DW        = 4 * NUM_DIGITS;

  logic [9:0]            sw_meta_q, sw_q;
  mode_e                 mode;
  logic [3:0]            pressed, press;
  logic                  unused_key3;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  tick_q, tick_d, tgl_q;
  logic                  run, clr, ld, stp;
  logic [DW-1:0]         disp;
  logic [7:0]            cnt_lo;
  logic [9:0]            ledr_q, ledr_d;
  logic [7:0]            ledg_q, ledg_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

  function automatic logic [7*NUM_DIGITS-1:0] id_hex();
    logic [7*NUM_DIGITS-1:0] r;
    r = '1;
    for (int i = 0; i < ID_DIGITS; i++) r[7*i +: 7] = hex_to_seg(CLASS_ID[4*i +: 4]);
    return r;
  endfunction

  key_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk_i    (clock),
    .rst_i    (reset),
    .key_n_i  (pnl.key),
    .pressed_o(pressed),
    .press_o  (press)
  );

  // key3 has no press action in any mode; only its level reaches ledg.
  assign unused_key3 = press[3];

  assign mode = decode_mode(sw_q[9:5]);

  // Counter view zero-extended or truncated to what the digits / LEDs can show.
  if (CNT_WIDTH >= DW) begin : g_disp_trunc
    assign disp = count_q[DW-1:0];
  end else begin : g_disp_ext
    assign disp = {{(DW - CNT_WIDTH){1'b0}}, count_q};
  end
  if (CNT_WIDTH >= 8) begin : g_lo_trunc
    assign cnt_lo = count_q[7:0];
  end else begin : g_lo_ext
    assign cnt_lo = {{(8 - CNT_WIDTH){1'b0}}, count_q};
  end

  // Counter, wrap flag and prescaler next state.
  always_comb begin
    run     = (mode == MODE_AUTO) && sw_q[1];
    presc_d = '0;
    tick_d  = 1'b0;
    if (run) begin
      if (presc_q == TICK_LAST) tick_d = 1'b1;
      else                      presc_d = presc_q + PW'(1);
    end

    // Presses in modes that do not use that key fall through untouched.
    clr = ((mode == MODE_MANUAL) || (mode == MODE_AUTO)) && press[1];
    ld  = (mode == MODE_AUTO) && press[2];
    stp = ((mode == MODE_MANUAL) && press[0]) || ((mode == MODE_AUTO) && tick_q);

    count_d = count_q;
    wrap_d  = wrap_q;
    if (clr) begin
      count_d = '0;
      wrap_d  = 1'b0;
    end else if (ld) begin
      count_d = {{(CNT_WIDTH - 3){1'b0}}, sw_q[4:2]};
      wrap_d  = 1'b0;
    end else if (stp) begin
      if (sw_q[0]) begin
        count_d = count_q - CNT_WIDTH'(1);
        if (count_q == '0) wrap_d = 1'b1;
      end else begin
        count_d = count_q + CNT_WIDTH'(1);
        if (count_q == '1) wrap_d = 1'b1;
      end
    end
  end

  // Display / LED mux feeding the output registers.
  always_comb begin
    hex_d = '1;
    case (mode)
      MODE_ID: hex_d = id_hex();
      MODE_ECHO: begin
        for (int i = 0; i < NUM_DIGITS; i++) hex_d[7*i +: 7] = SEG_0;
        hex_d[6:0] = hex_to_seg(sw_q[3:0]);
      end
      MODE_MANUAL, MODE_AUTO: begin
        for (int i = 0; i < NUM_DIGITS; i++) hex_d[7*i +: 7] = hex_to_seg(disp[4*i +: 4]);
      end
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++) hex_d[7*i +: 7] = SEG_BLANK;
      end
    endcase
    ledr_d = {(mode == MODE_INVALID), wrap_q, cnt_lo};
    ledg_d = {tgl_q, 3'b000, pressed};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_q      <= '0;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      tgl_q     <= 1'b0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      hex_q     <= id_hex();
    end else begin
      sw_meta_q <= pnl.sw;
      sw_q      <= sw_meta_q;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      tgl_q     <= tgl_q ^ tick_q;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      hex_q     <= hex_d;
    end
  end

  assign pnl.ledr = ledr_q;
  assign pnl.ledg = ledg_q;
  assign pnl.hex  = hex_q;

endmodule

// File: tb/tb_de1_counter_display.sv
module tb_de1_counter_display;
  localparam int D  = 4;
  localparam int T  = 10;
  localparam int ND = 4;
  localparam int CW = 16;

  localparam logic [6:0] SEGS [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [27:0] ID_HEX    = {7'h40, 7'h40, 7'h78, 7'h02};
  localparam logic [27:0] BLANK_HEX = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  de1_counter_display_if #(.NUM_DIGITS(ND)) bus ();

  de1_counter_display #(
    .CNT_WIDTH      (CW),
    .NUM_DIGITS     (ND),
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES    (T),
    .CLASS_ID       (16'h0076)
  ) dut (
    .clock(clk),
    .reset(rst),
    .pnl  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model of the counter: plain modular arithmetic.
  int unsigned m_cnt  = 0;
  bit          m_wrap = 1'b0;

  typedef struct {
    logic [9:0]  sw;
    logic [27:0] hex;
    logic        inv;
    string       name;
  } vec_t;
  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [9:0] v);
    bus.sw = v;
    cyc(4);
  endtask

  task automatic m_step(input bit dn);
    if (dn) begin
      if (m_cnt == 0) m_wrap = 1'b1;
      m_cnt = (m_cnt + 32'hFFFF) & 32'hFFFF;
    end else begin
      if (m_cnt == 32'hFFFF) m_wrap = 1'b1;
      m_cnt = (m_cnt + 1) & 32'hFFFF;
    end
  endtask

  function automatic logic [27:0] cnt_hex(input int unsigned v);
    logic [27:0] r;
    for (int i = 0; i < 4; i++) r[7*i +: 7] = SEGS[(v >> (4*i)) & 15];
    return r;
  endfunction

  // Hold the masked keys down long enough to be accepted, then release.
  task automatic press(input logic [3:0] mask, input bit bounce, input string nm);
    if (bounce) begin
      repeat (2) begin
        bus.key = ~mask;
        cyc(2);
        bus.key = 4'hF;
        cyc(2);
      end
    end
    bus.key = ~mask;
    cyc(D + 6);
    check({nm, " held ledg"}, 32'(bus.ledg[3:0]), 32'(mask));
    bus.key = 4'hF;
    cyc(D + 6);
  endtask

  task automatic check_counter(input string nm);
    check({nm, " ledr"}, 32'(bus.ledr), 32'({1'b0, m_wrap, 8'(m_cnt)}));
    check({nm, " hex"}, 32'(bus.hex), 32'(cnt_hex(m_cnt)));
  endtask

  int   tog;
  logic prev;
  bit   dn;
  bit   evt;
  int unsigned r;

  initial begin
    vt[0] = '{10'h000, ID_HEX, 1'b0, "id"};
    vt[1] = '{10'h00F, ID_HEX, 1'b0, "id sw noise"};
    vt[2] = '{10'h205, {7'h40, 7'h40, 7'h40, 7'h12}, 1'b0, "echo 5"};
    vt[3] = '{10'h20A, {7'h40, 7'h40, 7'h40, 7'h08}, 1'b0, "echo A"};
    vt[4] = '{10'h21F, {7'h40, 7'h40, 7'h40, 7'h0E}, 1'b0, "echo F"};
    vt[5] = '{10'h300, BLANK_HEX, 1'b1, "inv 11000"};
    vt[6] = '{10'h3E0, BLANK_HEX, 1'b1, "inv 11111"};
    vt[7] = '{10'h020, BLANK_HEX, 1'b1, "inv 00001"};

    // Reset state
    rst     = 1'b1;
    bus.sw  = 10'h000;
    bus.key = 4'hF;
    cyc(3);
    check("reset hex", 32'(bus.hex), 32'(ID_HEX));
    check("reset ledr", 32'(bus.ledr), 32'h0);
    check("reset ledg", 32'(bus.ledg), 32'h0);
    rst = 1'b0;
    cyc(3);
    check("post-reset hex", 32'(bus.hex), 32'(ID_HEX));

    // Static mode table
    for (int i = 0; i < 8; i++) begin
      set_sw(vt[i].sw);
      check({vt[i].name, " hex"}, 32'(bus.hex), 32'(vt[i].hex));
      check({vt[i].name, " ledr9"}, 32'(bus.ledr[9]), 32'(vt[i].inv));
    end

    // MANUAL up: three presses, the second with short glitches
    set_sw(10'h100);
    for (int i = 0; i < 3; i++) begin
      press(4'b0001, (i == 1), "man up");
      m_step(1'b0);
    end
    check_counter("man up x3");

    // MANUAL down from zero wraps, key1 clears
    press(4'b0010, 1'b0, "man clr");
    m_cnt = 0; m_wrap = 1'b0;
    set_sw(10'h101);
    press(4'b0001, 1'b0, "man dn");
    m_step(1'b1);
    check_counter("man dn wrap");
    press(4'b0010, 1'b0, "man clr2");
    m_cnt = 0; m_wrap = 1'b0;
    check_counter("man clr");

    // AUTO: ticks every T cycles while sw[1]=1
    set_sw(10'h080);
    press(4'b0010, 1'b0, "auto clr");
    m_cnt = 0; m_wrap = 1'b0;
    bus.sw = 10'h082;
    prev = bus.ledg[7];
    tog  = 0;
    for (int i = 0; i < 55; i++) begin
      cyc(1);
      if (bus.ledg[7] !== prev) tog++;
      prev = bus.ledg[7];
    end
    bus.sw = 10'h080;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (bus.ledg[7] !== prev) tog++;
      prev = bus.ledg[7];
    end
    for (int k = 0; k < 55 / T; k++) m_step(1'b0);
    check("auto tick toggles", 32'(tog), 32'(55 / T));
    check_counter("auto run");
    cyc(30);
    check_counter("auto frozen");

    // AUTO: clear beats load in the same cycle, then load alone
    set_sw(10'h094);
    press(4'b0110, 1'b0, "clr+ld");
    m_cnt = 0; m_wrap = 1'b0;
    check_counter("clr beats ld");
    press(4'b0100, 1'b0, "ld");
    m_cnt = 5; m_wrap = 1'b0;
    check_counter("load 5");

    // INVALID: blank, flag, counter frozen
    set_sw(10'h300);
    check("inv hex", 32'(bus.hex), 32'(BLANK_HEX));
    check("inv ledr9", 32'(bus.ledr[9]), 32'h1);
    press(4'b0001, 1'b0, "inv key0");
    check("inv frozen", 32'(bus.ledr[8:0]), 32'({m_wrap, 8'(m_cnt)}));

    // Random MANUAL walk around zero against the model
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        press(4'b0010, 1'b0, "rnd clr");
        m_cnt = 0; m_wrap = 1'b0;
      end else begin
        dn = 1'($urandom_range(0, 1));
        set_sw(10'h100 | 10'(dn));
        press(4'b0001, 1'($urandom_range(0, 1)), "rnd step");
        m_step(dn);
      end
      check_counter("rnd manual");
    end

    // Random ECHO values
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(0, 15);
      set_sw(10'h200 | 10'(r));
      check("rnd echo hex", 32'(bus.hex), 32'({SEGS[0], SEGS[0], SEGS[0], SEGS[r]}));
    end

    // Reset in the middle of a debounce window: no event afterwards
    set_sw(10'h100);
    bus.key = 4'hE;
    cyc(4);
    rst = 1'b1;
    cyc(2);
    bus.key = 4'hF;
    cyc(2);
    rst = 1'b0;
    m_cnt = 0; m_wrap = 1'b0;
    evt = 1'b0;
    for (int i = 0; i < D + 10; i++) begin
      cyc(1);
      if (bus.ledg[0] !== 1'b0 || bus.ledr[7:0] !== 8'h00) evt = 1'b1;
    end
    check("reset mid-debounce event", 32'(evt), 32'h0);
    check_counter("after reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/de1_counter_display.md
# de1_counter_display

Parametrised front-panel controller for the DE1 board: selects a display mode from the slide switches and drives N seven-segment digits, red and green LEDs. Modes cover:
- class-ID display;
- single hex digit echo;
- key-stepped up/down counter;
- free-running prescaled counter with load.

Sits directly under the board top level and replaces the per-lab combinational decoders with one debounced, registered block.

## Interface
- `CNT_WIDTH`, 16, counter width in bits (4..32).
- `NUM_DIGITS`, 4, number of 7-seg digits driven (1..8).
- `DEBOUNCE_CYCLES`, 240000, cycles a key level must be stable to be accepted (10 ms at 24 MHz).
- `TICK_CYCLES`, 24000000, clock cycles per auto-count tick (1 Hz at 24 MHz).
- `CLASS_ID`, 16'h0076, BCD/hex digits shown in ID mode, digit 0 = least-significant nibble.

Ports:
- `clock`  in  1  24 MHz board clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `sw`  in  10  slide switches, asynchronous to `clock`.
- `key`  in  4  pushbuttons, active-low, asynchronous, bouncing.
- `ledr`  out  10  red LEDs.
- `ledg`  out  8  green LEDs.
- `hex`  out  7*NUM_DIGITS  segments, active-low, digit i at [7i+6:7i], bit order gfedcba.

## Operation
- Inputs `sw` and `key` pass through 2-flop synchronisers.
- Keys are debounced: the accepted level updates after DEBOUNCE_CYCLES consecutive equal samples. A press event is a one-cycle pulse on an accepted 1->0 transition. Release generates nothing.
- Mode is decoded from synchronised `sw[9:5]`:
  - 00000 ID: digits show CLASS_ID nibbles; digits beyond 4 are blank (7'h7F).
  - 10000 ECHO: digit 0 = hex of `sw[3:0]`; other digits show 0.
  - 01000 MANUAL: key0 press steps the counter by ±1. Direction is down if `sw[0]`=1, else up. key1 press clears the counter.
  - 00100 AUTO: while `sw[1]`=1 the prescaler runs and each tick steps the counter (direction `sw[0]`). key1 clears. key2 loads `sw[4:2]` zero-extended into the counter.
  - Any other code is INVALID: all digits blank, `ledr[9]`=1, counter frozen.
- The counter persists across mode changes. It is displayed in MANUAL/AUTO as the low 4*NUM_DIGITS bits (zero-extended if CNT_WIDTH is smaller), hex glyphs 0-F.
- Arithmetic is modulo 2^CNT_WIDTH. An up-step from all-ones or a down-step from zero sets the sticky `wrap` flag. `wrap` clears on clear, load, or reset.
- Priority within one cycle: clear > load > step. A key press in a mode that does not use it is discarded.
- Prescaler is held at 0 when the mode is not AUTO or `sw[1]`=0. A tick fires when it reaches TICK_CYCLES-1, then it returns to 0.
- Outputs:
  - `ledr[7:0]` = count[7:0]; `ledr[8]` = wrap; `ledr[9]` = invalid mode.
  - `ledg[3:0]` = debounced pressed state of key3..0 (1 = pressed); `ledg[6:4]` = 0; `ledg[7]` toggles on each tick.

## Timing
- Reset values (asynchronous):
  - counter = 0, wrap = 0, prescaler = 0, debounced keys = released.
  - `ledr` = 0, `ledg` = 0.
  - `hex` = ID pattern (CLASS_ID on digits 0-3, rest blank).
- Synchroniser latency is 2 cycles. A press pulse occurs DEBOUNCE_CYCLES+2 cycles after the first edge sampling the new key level, provided it stays stable.
- The counter updates on the cycle after the press/tick pulse. `hex`/`ledr` are registered and update one further cycle later. Mode changes reach `hex` in 3 cycles.
- A bounce shorter than DEBOUNCE_CYCLES produces no event. A key held down produces exactly one event.
- Reset mid-debounce or mid-prescale discards the partial count. No event is emitted on reset deassertion, even if a key is held.

## Structure
- Package `de1_pkg` holds:
  - the mode enum (MODE_ID, MODE_ECHO, MODE_MANUAL, MODE_AUTO, MODE_INVALID);
  - segment constants SEG_BLANK=7'h7F, SEG_0..SEG_F;
  - function `hex_to_seg(4-bit) -> 7-bit`.
- Sub-module `key_debounce` (params WIDTH, DEBOUNCE_CYCLES) contains the synchroniser, stability counters and press pulses. It is instantiated once with WIDTH=4.
- The top level contains the mode decoder, counter/prescaler, and registered display mux.

## Test plan
Simulation parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=10, NUM_DIGITS=4, CNT_WIDTH=16.
1. Reset with `sw`=0 -> `hex`={7'h40,7'h40,7'h78,7'h02} (digits 3..0 = "0076"), `ledr`=0, `ledg`=0.
2. MANUAL, `sw[0]`=0: three clean key0 presses, one with 2-cycle bounce glitches -> count=3, exactly 3 steps, digit 0 = 7'h30.
3. MANUAL, `sw[0]`=1 from count 0: one press -> count=16'hFFFF, `ledr[8]`=1, all digits 7'h0E. A key1 press then gives count 0, `ledr[8]`=0.
4. AUTO, `sw[1]`=1, `sw[0]`=0 for 50 cycles -> exactly 5 ticks, count=5, `ledg[7]` toggled 5 times. Setting `sw[1]`=0 freezes count.
5. AUTO: key1 and key2 press events in the same cycle with `sw[4:2]`=3'b101 -> count=0, clear wins. key2 alone -> count=5.
6. `sw[9:5]`=11000 -> all digits 7'h7F, `ledr[9]`=1, key0 presses ignored. Asserting reset mid-debounce -> no event after release of reset.
